alu_rr_sequencer: RTL and testbench

Round-robin controller that shares the board's single 3-bit signed ALU (add, sub, AND, OR) between two requesters. It accepts one operation at a time through a req/gnt handshake and registers the result with the requester's ID. The result is held on a valid/ready response port, drives the 7-segment display, and is counted for the LED bank. It sits between the switch/requester logic and the display in `top`.

---
 rtl/alu_rr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer
// Shares one small two's-complement ALU (add, sub, AND, OR) between two
// requesters using round-robin arbitration. One operation is in flight at a
// time: accept (IDLE) -> compute (EXEC) -> hold result on a valid/ready port
// (RESP). Consumed results drive the 7-segment code and a wrapping counter.
module alu_rr_sequencer #(
    parameter int NBITS    = 3,
    parameter int CNT_BITS = 8
) (
    input  logic                clk_2,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [NBITS-1:0]    a0,
    input  logic [NBITS-1:0]    b0,
    input  logic [1:0]          f0,
    input  logic [NBITS-1:0]    a1,
    input  logic [NBITS-1:0]    b1,
    input  logic [1:0]          f1,
    output logic [1:0]          gnt,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [NBITS-1:0]    resp_y,
    output logic                resp_ovf,
    output logic [7:0]          SEG,
    output logic [CNT_BITS-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic                    last_id;
    logic signed [NBITS-1:0] op_a;
    logic signed [NBITS-1:0] op_b;
    logic [1:0]              op_f;
    logic                    win_id;
    logic [NBITS:0]          alu_out;

    // ALU: returns {ovf, y}; y is the low NBITS bits of the signed result.
    function automatic logic [NBITS:0] alu_calc(
        input logic signed [NBITS-1:0] a,
        input logic signed [NBITS-1:0] b,
        input logic [1:0]              f
    );
        logic signed [NBITS-1:0] y;
        logic                    ovf;
        y   = '0;
        ovf = 1'b0;
        case (f)
            2'b00: begin
                y   = a + b;
                ovf = (a[NBITS-1] == b[NBITS-1]) && (y[NBITS-1] != a[NBITS-1]);
            end
            2'b01: begin
                y   = a - b;
                ovf = (a[NBITS-1] != b[NBITS-1]) && (y[NBITS-1] != a[NBITS-1]);
            end
            2'b10:   y = a & b;
            default: y = a | b;
        endcase
        return {ovf, y};
    endfunction

    // 7-segment code; overflow shows only the decimal point. Negative values
    // light the decimal point together with their magnitude digit.
    function automatic logic [7:0] seg_encode(
        input logic [NBITS-1:0] y,
        input logic             ovf
    );
        logic [2:0] y3;
        logic [7:0] seg;
        y3 = y[2:0];
        if (ovf) begin
            seg = 8'h80;
        end else begin
            case (y3)
                3'd0:    seg = 8'h3F;
                3'd1:    seg = 8'h06;
                3'd2:    seg = 8'h5B;
                3'd3:    seg = 8'h4F;
                3'd4:    seg = 8'hE6;
                3'd5:    seg = 8'hCF;
                3'd6:    seg = 8'hDB;
                default: seg = 8'h86;
            endcase
        end
        return seg;
    endfunction

    // Round-robin winner: a lone request wins; on a tie, the requester not served last.
    always_comb begin
        win_id = 1'b0;
        if (req == 2'b10)
            win_id = 1'b1;
        else if (req == 2'b11)
            win_id = ~last_id;
    end

    // Combinational ALU on the operands latched at acceptance.
    always_comb begin
        alu_out = alu_calc(op_a, op_b, op_f);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_id    <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_f       <= 2'b00;
            gnt        <= 2'b00;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_y     <= '0;
            resp_ovf   <= 1'b0;
            SEG        <= 8'h00;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        op_a    <= win_id ? a1 : a0;
                        op_b    <= win_id ? b1 : b0;
                        op_f    <= win_id ? f1 : f0;
                        gnt     <= win_id ? 2'b10 : 2'b01;
                        last_id <= win_id;
                        state   <= EXEC;
                    end else begin
                        gnt <= 2'b00;
                    end
                end
                EXEC: begin
                    gnt        <= 2'b00;
                    resp_y     <= alu_out[NBITS-1:0];
                    resp_ovf   <= alu_out[NBITS];
                    resp_id    <= last_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    // Result stays frozen until the consumer takes it.
                    if (resp_ready) begin
                        SEG        <= seg_encode(resp_y, resp_ovf);
                        op_count   <= op_count + CNT_BITS'(1);
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed testbench for alu_rr_sequencer with hand-computed expectations.
module tb_alu_rr_sequencer;

    localparam int NBITS    = 3;
    localparam int CNT_BITS = 8;

    logic                clk_2;
    logic                reset;
    logic [1:0]          req;
    logic [NBITS-1:0]    a0, b0, a1, b1;
    logic [1:0]          f0, f1;
    logic [1:0]          gnt;
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_id;
    logic [NBITS-1:0]    resp_y;
    logic                resp_ovf;
    logic [7:0]          SEG;
    logic [CNT_BITS-1:0] op_count;

    int n_checks;
    int n_fail;

    alu_rr_sequencer #(.NBITS(NBITS), .CNT_BITS(CNT_BITS)) dut (
        .clk_2      (clk_2),
        .reset      (reset),
        .req        (req),
        .a0         (a0),
        .b0         (b0),
        .f0         (f0),
        .a1         (a1),
        .b1         (b1),
        .f1         (f1),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_y     (resp_y),
        .resp_ovf   (resp_ovf),
        .SEG        (SEG),
        .op_count   (op_count)
    );

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk_2);
        @(negedge clk_2);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"},   32'(gnt),        32'h0);
        chk({tag, "_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_id"},    32'(resp_id),    32'h0);
        chk({tag, "_y"},     32'(resp_y),     32'h0);
        chk({tag, "_ovf"},   32'(resp_ovf),   32'h0);
        chk({tag, "_seg"},   32'(SEG),        32'h00);
        chk({tag, "_cnt"},   32'(op_count),   32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req        = 2'b00;
        resp_ready = 1'b0;
        a0 = '0; b0 = '0; f0 = 2'b00;
        a1 = '0; b1 = '0; f1 = 2'b00;

        // ---- reset values
        step();
        step();
        check_reset_vals("rst");
        reset = 1'b0;
        step();

        // ---- 3 - 2 from requester 0
        req = 2'b01; a0 = 3'd3; b0 = 3'd2; f0 = 2'b01;
        step();                                   // accepting edge
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_valid_early", 32'(resp_valid), 32'h0);
        req = 2'b00;
        step();                                   // into RESP
        chk("t1_gnt_drop", 32'(gnt), 32'h0);
        chk("t1_valid", 32'(resp_valid), 32'h1);
        chk("t1_y", 32'(resp_y), 32'h1);
        chk("t1_ovf", 32'(resp_ovf), 32'h0);
        chk("t1_id", 32'(resp_id), 32'h0);
        chk("t1_seg_before", 32'(SEG), 32'h00);
        resp_ready = 1'b1;
        step();                                   // consume
        resp_ready = 1'b0;
        chk("t1_seg", 32'(SEG), 32'h06);
        chk("t1_cnt", 32'(op_count), 32'h1);
        chk("t1_valid_off", 32'(resp_valid), 32'h0);

        // ---- 3 + 1 overflows to -4
        req = 2'b01; a0 = 3'd3; b0 = 3'd1; f0 = 2'b00;
        step();
        chk("t2_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        step();
        chk("t2_y", 32'(resp_y), 32'h4);
        chk("t2_ovf", 32'(resp_ovf), 32'h1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t2_seg", 32'(SEG), 32'h80);
        chk("t2_cnt", 32'(op_count), 32'h2);

        // ---- lone requester 1: -4 - 1 overflows to 3
        req = 2'b10; a1 = 3'd4; b1 = 3'd1; f1 = 2'b01;
        step();
        chk("t2b_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        step();
        chk("t2b_y", 32'(resp_y), 32'h3);
        chk("t2b_ovf", 32'(resp_ovf), 32'h1);
        chk("t2b_id", 32'(resp_id), 32'h1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("t2b_seg", 32'(SEG), 32'h80);
        chk("t2b_cnt", 32'(op_count), 32'h3);

        // ---- round robin with both requesting, ready held
        do_reset();
        req = 2'b11; resp_ready = 1'b1;
        a0 = 3'd2; b0 = 3'd3; f0 = 2'b10;         // 2 AND 3 = 2
        a1 = 3'd5; b1 = 3'd2; f1 = 2'b11;         // -3 OR 2 = -1
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            chk("rr_valid", 32'(resp_valid), 32'h1);
            chk("rr_y", 32'(resp_y), (k % 2 == 0) ? 32'h2 : 32'h7);
            chk("rr_id", 32'(resp_id), (k % 2 == 0) ? 32'h0 : 32'h1);
            step();
            chk("rr_seg", 32'(SEG), (k % 2 == 0) ? 32'h5B : 32'h86);
            chk("rr_cnt", 32'(op_count), 32'(k + 1));
        end
        req = 2'b00; resp_ready = 1'b0;

        // ---- resp_ready outside RESP is ignored
        resp_ready = 1'b1;
        step();
        step();
        chk("idle_ready_cnt", 32'(op_count), 32'h6);
        resp_ready = 1'b0;

        // ---- stall in RESP for 10 cycles: 1 + 1 = 2
        req = 2'b01; a0 = 3'd1; b0 = 3'd1; f0 = 2'b00;
        step();
        req = 2'b00;
        step();
        for (int k = 0; k < 10; k++) begin
            req = (k % 2 == 0) ? 2'b11 : 2'b00;
            a0 = 3'd7; a1 = 3'd6;
            step();
            chk("stall_gnt", 32'(gnt), 32'h0);
            chk("stall_valid", 32'(resp_valid), 32'h1);
            chk("stall_y", 32'(resp_y), 32'h2);
            chk("stall_id", 32'(resp_id), 32'h0);
            chk("stall_seg", 32'(SEG), 32'h86);
            chk("stall_cnt", 32'(op_count), 32'h6);
        end
        req = 2'b00;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("stall_seg_after", 32'(SEG), 32'h5B);
        chk("stall_cnt_after", 32'(op_count), 32'h7);

        // ---- asynchronous reset while in RESP
        req = 2'b10; a1 = 3'd1; b1 = 3'd2; f1 = 2'b00;
        step();
        req = 2'b00;
        step();
        chk("ar_valid_pre", 32'(resp_valid), 32'h1);
        chk("ar_y_pre", 32'(resp_y), 32'h3);
        resp_ready = 1'b1;
        #1 reset = 1'b1;
        #1 check_reset_vals("arst");
        step();
        reset = 1'b0;
        step();
        chk("arst_cnt_after", 32'(op_count), 32'h0);
        chk("arst_seg_after", 32'(SEG), 32'h00);
        resp_ready = 1'b0;
        // last_id back to 1: the first tie goes to requester 0
        req = 2'b11;
        step();
        chk("arst_tie_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        step();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // ---- counter wrap: 256 consumed operations
        do_reset();
        req = 2'b01; a0 = 3'd0; b0 = 3'd0; f0 = 2'b00; resp_ready = 1'b1;
        repeat (255 * 3) step();
        chk("wrap_255", 32'(op_count), 32'd255);
        chk("wrap_seg", 32'(SEG), 32'h3F);
        repeat (3) step();
        chk("wrap_0", 32'(op_count), 32'd0);
        req = 2'b00; resp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
